// File: rtl/i2c_target.sv
// I2C target responder: oversampled SCL/SDA, fixed address match,
// byte-stream write delivery and host-fed read data. No clock stretching.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       i2c_clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    MACK
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync;
  logic [1:0]  sda_sync;
  logic        scl_d;
  logic        sda_d;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        ack_drv;
  logic        tx_load;
  logic        sda_oe;

  logic scl_s;
  logic sda_in;
  logic scl_hi;
  logic start_ev;
  logic stop_ev;
  logic scl_rise;
  logic scl_fall;

  // Open-drain: only ever pull low, otherwise let the bus float high.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Synchronize the bus lines and keep one cycle of history for edges.
  // Idle bus is high, so reset to 1 to avoid phantom edges.
  always_ff @(posedge i2c_clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_in   = sda_sync[1];
  assign scl_hi   = scl_s & scl_d;
  assign start_ev = scl_hi & sda_d & ~sda_in;
  assign stop_ev  = scl_hi & ~sda_d & sda_in;
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  // Protocol FSM: START/STOP override everything, otherwise
  // sample on SCL rise and change the SDA drive on SCL fall.
  always_ff @(posedge i2c_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd7;
      shreg    <= 8'h00;
      ack_drv  <= 1'b0;
      tx_load  <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_ev) begin
        state   <= ADDR;
        bit_cnt <= 3'd7;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        tx_load <= 1'b0;
      end else if (stop_ev) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
        tx_load <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
          end
          ADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_in};
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                if (shreg[6:0] == TARGET_ADDR) begin
                  state   <= ADDR_ACK;
                  rw      <= sda_in;
                  busy    <= 1'b1;
                  ack_drv <= 1'b0;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                ack_drv <= 1'b1;
                sda_oe  <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                bit_cnt <= 3'd7;
                if (rw) begin
                  shreg  <= tx_data;
                  sda_oe <= ~tx_data[7];
                  state  <= READ;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= WRITE;
                end
              end
            end else if (scl_rise && ack_drv && rw) begin
              tx_req <= 1'b1;
            end
          end
          WRITE: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda_in};
              bit_cnt <= bit_cnt - 3'd1;
              if (bit_cnt == 3'd0) begin
                rx_data  <= {shreg[6:0], sda_in};
                rx_valid <= 1'b1;
                ack_drv  <= 1'b0;
                state    <= WRITE_ACK;
              end
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                ack_drv <= 1'b1;
                sda_oe  <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd7;
                state   <= WRITE;
              end
            end
          end
          READ: begin
            if (scl_fall) begin
              if (tx_load) begin
                tx_load <= 1'b0;
                shreg   <= tx_data;
                sda_oe  <= ~tx_data[7];
                bit_cnt <= 3'd7;
              end else if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= MACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end
          MACK: begin
            if (scl_rise) begin
              if (!sda_in) begin
                tx_req  <= 1'b1;
                tx_load <= 1'b1;
                state   <= READ;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level controller model, host model
// and scoreboard queues of expected written bytes / read bytes.
module tb_i2c_target;

  logic       i2c_clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] host_q[$];

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 i2c_clk = ~i2c_clk;

  i2c_target #(.TARGET_ADDR(7'h50)) dut (
    .i2c_clk (i2c_clk),
    .rst     (rst),
    .scl     (scl),
    .sda     (sda),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .rw      (rw),
    .busy    (busy)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every DUT output pulse against the queues.
  initial begin
    forever begin
      @(negedge i2c_clk);
      if (rx_valid) begin
        if (exp_rx.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_unexpected: got rx_data %0h, required no rx_valid",
                   rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
          check("rx_rw", 32'(rw), 32'd0);
        end
      end
      if (tx_req) begin
        if (host_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got tx_req, required none");
        end else begin
          tx_data = host_q.pop_front();
          check("txreq_rw", 32'(rw), 32'd1);
          check("txreq_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i2c_clk);
  endtask

  // START (also works as a repeated START from SCL low).
  task automatic bus_start();
    cyc(4); m_low = 1'b0;
    cyc(4); scl = 1'b1;
    cyc(8); m_low = 1'b1;
    cyc(8); scl = 1'b0;
  endtask

  task automatic bus_stop();
    cyc(4); m_low = 1'b1;
    cyc(4); scl = 1'b1;
    cyc(8); m_low = 1'b0;
    cyc(8);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    cyc(4); m_low = ~b;
    cyc(4); scl = 1'b1;
    cyc(4); s = sda;
    cyc(4); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(nack, s);
  endtask

  // One transfer: expectations are derived from address/direction
  // and queued before the bus activity starts.
  task automatic xfer(input logic [6:0] a, input logic r, input int n,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic stop_end);
    logic [7:0] d [3];
    logic       ack;
    logic [7:0] got;
    logic       match;
    d = '{d0, d1, d2};
    match = (a == 7'h50);
    if (match)
      for (int i = 0; i < n; i++)
        if (r) host_q.push_back(d[i]);
        else   exp_rx.push_back(d[i]);
    bus_start();
    send_byte({a, r}, ack);
    check("addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
    check("busy_match", 32'(busy), 32'(match));
    if (match) begin
      check("rw", 32'(rw), 32'(r));
      for (int i = 0; i < n; i++) begin
        if (r) begin
          recv_byte(got, i == n - 1);
          check("read_byte", 32'(got), 32'(d[i]));
        end else begin
          send_byte(d[i], ack);
          check("data_ack", 32'(ack), 32'd0);
        end
      end
      if (r) begin
        cyc(4);
        check("sda_released", 32'(sda), 32'd1);
      end
    end
    if (stop_end) bus_stop();
    cyc(4);
    check("q_drained", 32'(exp_rx.size() + host_q.size()), 32'd0);
    if (stop_end || !match || r)
      check("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [6:0] ra;
    rst = 1'b1;
    scl = 1'b1;
    m_low = 1'b0;
    tx_data = 8'h00;
    cyc(3);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    rst = 1'b0;
    cyc(8);

    // Plain write of one byte.
    xfer(7'h50, 1'b0, 1, 8'hA5, 8'h00, 8'h00, 1'b1);
    check("rx_data_a5", 32'(rx_data), 32'hA5);

    // Wrong address: silent.
    xfer(7'h51, 1'b0, 1, 8'h00, 8'h00, 8'h00, 1'b1);

    // Two-byte read, ACK then NACK.
    xfer(7'h50, 1'b1, 2, 8'h3C, 8'hC3, 8'h00, 1'b1);

    // Write then repeated START into a read.
    xfer(7'h50, 1'b0, 1, 8'h12, 8'h00, 8'h00, 1'b0);
    xfer(7'h50, 1'b1, 1, 8'h9E, 8'h00, 8'h00, 1'b1);
    check("rx_data_hold", 32'(rx_data), 32'h12);

    // Reset while the target drives the address ACK of a read.
    host_q.push_back(8'h00);
    bus_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'hA1;
      bus_bit(ab[i], s);
    end
    cyc(4); m_low = 1'b0;
    cyc(4); scl = 1'b1;
    cyc(4);
    check("ack_before_rst", 32'(sda), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_sda", 32'(sda), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rw", 32'(rw), 32'd0);
    check("rst_mid_rx_data", 32'(rx_data), 32'd0);
    check("rst_mid_tx_req", 32'(tx_req), 32'd0);
    check("rst_mid_host_q", 32'(host_q.size()), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(8);
    xfer(7'h50, 1'b0, 2, 8'h5A, 8'hF0, 8'h00, 1'b1);

    // STOP after four data bits of a write.
    bus_start();
    send_byte(8'hA0, ack);
    check("abort_addr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) bus_bit(i[0], s);
    bus_stop();
    cyc(4);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx_data", 32'(rx_data), 32'hF0);
    xfer(7'h50, 1'b0, 1, 8'h77, 8'h00, 8'h00, 1'b1);

    // Randomized transfers.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        ra = 7'($urandom);
        if (ra == 7'h50) ra = 7'h51;
      end else begin
        ra = 7'h50;
      end
      xfer(ra, 1'($urandom), int'($urandom_range(1, 3)),
           8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom));
    end
    bus_stop();
    cyc(8);
    check("final_busy", 32'(busy), 32'd0);
    check("final_queues", 32'(exp_rx.size() + host_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
